// File: rtl/lfsr_keystream_gen.sv
// lfsr_keystream_gen: seedable Fibonacci LFSR packing one bit per cycle into MSB-first bytes over valid/ready
module lfsr_keystream_gen #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic             stop,
    input  logic             ks_ready,
    output logic             ks_valid,
    output logic [7:0]       ks_byte,
    output logic             busy,
    output logic             seed_err,
    output logic [WIDTH-1:0] state_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    logic [1:0]       fsm;
    logic [WIDTH-1:0] lfsr;
    logic [2:0]       count;
    logic [7:0]       pack;
    logic             stop_pending;
    logic             fb;
    assign fb        = ^(lfsr & TAPS);
    assign busy      = fsm != IDLE;
    assign state_out = lfsr;
    always_ff @(posedge clk) begin
        if (clear) begin
            lfsr         <= SEED_DEFAULT;
            fsm          <= IDLE;
            count        <= '0;
            pack         <= '0;
            stop_pending <= 1'b0;
            ks_valid     <= 1'b0;
            ks_byte      <= '0;
            seed_err     <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (load) begin
                        lfsr     <= (seed_in == '0) ? SEED_DEFAULT : seed_in;
                        seed_err <= seed_in == '0;
                    end else if (start) begin
                        fsm   <= RUN;
                        count <= '0;
                    end
                end
                RUN: begin
                    // stop wins over the shift, so a stop on the 8th cycle drops the byte
                    if (stop) begin
                        fsm <= IDLE;
                    end else begin
                        lfsr  <= {lfsr[WIDTH-2:0], fb};
                        pack  <= {pack[6:0], lfsr[WIDTH-1]};
                        count <= count + 3'd1;
                        if (count == 3'd7) begin
                            ks_byte  <= {pack[6:0], lfsr[WIDTH-1]};
                            ks_valid <= 1'b1;
                            fsm      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ks_valid && ks_ready) begin
                        ks_valid     <= 1'b0;
                        count        <= '0;
                        stop_pending <= 1'b0;
                        fsm          <= (stop_pending || stop) ? IDLE : RUN;
                    end else if (stop) begin
                        stop_pending <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// tb_lfsr_keystream_gen: directed checks of seeding, byte packing, backpressure, stop and clear
module tb_lfsr_keystream_gen;
    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ks_ready = 1'b0;
    logic        ks_valid;
    logic [7:0]  ks_byte;
    logic        busy;
    logic        seed_err;
    logic [15:0] state_out;
    int passed = 0;
    int total = 0;

    lfsr_keystream_gen dut (
        .clk(clk), .clear(clear), .load(load), .seed_in(seed_in), .start(start),
        .stop(stop), .ks_ready(ks_ready), .ks_valid(ks_valid), .ks_byte(ks_byte),
        .busy(busy), .seed_err(seed_err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        {load, start, stop, ks_ready} = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        total++;
        if (state_out !== 16'hACE1) $display("FAIL reset_state got %h want ACE1", state_out); else passed++;
        total++;
        if ({ks_valid, busy, seed_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {ks_valid, busy, seed_err}); else passed++;
        total++;
        if (ks_byte !== 8'h00) $display("FAIL reset_byte got %h want 00", ks_byte); else passed++;
    endtask

    task automatic test_stream();
        do_clear();
        ks_ready = 1'b1;
        do_start();
        tick(7);
        total++;
        if (ks_valid !== 1'b0) $display("FAIL stream_early got %b want 0", ks_valid); else passed++;
        tick();
        total++;
        if (ks_valid !== 1'b1 || ks_byte !== 8'hAC) $display("FAIL stream_b0 got v=%b %h want v=1 AC", ks_valid, ks_byte); else passed++;
        tick();
        total++;
        if (ks_valid !== 1'b0 || busy !== 1'b1) $display("FAIL stream_hs got v=%b busy=%b want v=0 busy=1", ks_valid, busy); else passed++;
        tick(7);
        total++;
        if (ks_valid !== 1'b0) $display("FAIL stream_gap got %b want 0", ks_valid); else passed++;
        tick();
        total++;
        if (ks_valid !== 1'b1 || ks_byte !== 8'hE1) $display("FAIL stream_b1 got v=%b %h want v=1 E1", ks_valid, ks_byte); else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (ks_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stream_end got v=%b busy=%b want 0 0", ks_valid, busy); else passed++;
    endtask

    task automatic test_load();
        do_clear();
        load = 1'b1;
        seed_in = 16'h0000;
        tick();
        total++;
        if (state_out !== 16'hACE1 || seed_err !== 1'b1) $display("FAIL load_zero got %h err=%b want ACE1 err=1", state_out, seed_err); else passed++;
        seed_in = 16'h1234;
        tick();
        total++;
        if (state_out !== 16'h1234 || seed_err !== 1'b0) $display("FAIL load_seed got %h err=%b want 1234 err=0", state_out, seed_err); else passed++;
        seed_in = 16'h00FF;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        tick(2);
        total++;
        if (state_out !== 16'h00FF || busy !== 1'b0) $display("FAIL load_prio got %h busy=%b want 00FF busy=0", state_out, busy); else passed++;
    endtask

    task automatic test_stop_run();
        do_clear();
        ks_ready = 1'b1;
        do_start();
        tick();
        total++;
        if (state_out !== 16'h59C3) $display("FAIL shift1 got %h want 59C3", state_out); else passed++;
        tick();
        total++;
        if (state_out !== 16'hB387) $display("FAIL shift2 got %h want B387", state_out); else passed++;
        tick();
        total++;
        if (state_out !== 16'h670F) $display("FAIL shift3 got %h want 670F", state_out); else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(10);
        total++;
        if (state_out !== 16'h670F || busy !== 1'b0 || ks_valid !== 1'b0) $display("FAIL stop_run got %h busy=%b v=%b want 670F 0 0", state_out, busy, ks_valid); else passed++;
    endtask

    task automatic test_backpressure();
        do_clear();
        do_start();
        tick(8);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ks_valid !== 1'b1 || ks_byte !== 8'hAC || state_out !== 16'hE1E4)
                $display("FAIL hold_%0d got v=%b %h %h want v=1 AC E1E4", i, ks_valid, ks_byte, state_out);
            else passed++;
            tick();
        end
        ks_ready = 1'b1;
        tick();
        total++;
        if (ks_valid !== 1'b0) $display("FAIL bp_hs got %b want 0", ks_valid); else passed++;
        tick(8);
        total++;
        if (ks_valid !== 1'b1 || ks_byte !== 8'hE1) $display("FAIL bp_b1 got v=%b %h want v=1 E1", ks_valid, ks_byte); else passed++;
    endtask

    task automatic test_stop_hold();
        do_clear();
        do_start();
        tick(8);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        total++;
        if (ks_valid !== 1'b1 || ks_byte !== 8'hAC || busy !== 1'b1) $display("FAIL sh_held got v=%b %h busy=%b want 1 AC 1", ks_valid, ks_byte, busy); else passed++;
        ks_ready = 1'b1;
        tick();
        total++;
        if (ks_valid !== 1'b0 || busy !== 1'b0 || ks_byte !== 8'hAC) $display("FAIL sh_idle got v=%b busy=%b %h want 0 0 AC", ks_valid, busy, ks_byte); else passed++;
        tick(10);
        total++;
        if (ks_valid !== 1'b0 || state_out !== 16'hE1E4) $display("FAIL sh_quiet got v=%b %h want 0 E1E4", ks_valid, state_out); else passed++;
    endtask

    task automatic test_clear_mid();
        do_clear();
        load = 1'b1;
        seed_in = 16'h0000;
        tick();
        load = 1'b0;
        do_start();
        tick(5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (state_out !== 16'hACE1 || {ks_valid, busy, seed_err} !== 3'b000 || ks_byte !== 8'h00)
            $display("FAIL clr_run got %h flags=%b %h want ACE1 000 00", state_out, {ks_valid, busy, seed_err}, ks_byte);
        else passed++;
        do_start();
        tick(8);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (state_out !== 16'hACE1 || {ks_valid, busy} !== 2'b00 || ks_byte !== 8'h00)
            $display("FAIL clr_hold got %h flags=%b %h want ACE1 00 00", state_out, {ks_valid, busy}, ks_byte);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load();
        test_stop_run();
        test_backpressure();
        test_stop_hold();
        test_clear_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lfsr_keystream_gen.md
Name: lfsr_keystream_gen

Overview:
- Keystream source for the crypto datapath, built on the same storage style as the team's dff/dff_set cells.
- Holds a WIDTH-bit Fibonacci LFSR state register that is seedable.
- Generates one keystream bit per cycle and packs bits MSB-first into bytes.
- Delivers each byte to the downstream XOR/cipher stage over a valid/ready handshake.

Parameters:
- WIDTH, 16, LFSR state width (at least 9).
- TAPS, 16'hB400, feedback mask; fb = XOR-reduce(state & TAPS).
- SEED_DEFAULT, 16'hACE1, state value after reset and substitute for an all-zero seed.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- load  in  1  load seed_in into the LFSR; honoured only in IDLE.
- seed_in  in  WIDTH  seed value.
- start  in  1  begin keystream generation; honoured only in IDLE.
- stop  in  1  end generation.
- ks_ready  in  1  downstream accepts ks_byte.
- ks_valid  out  1  ks_byte is valid.
- ks_byte  out  8  keystream byte; first generated bit is in bit 7.
- busy  out  1  high when the FSM is not in IDLE.
- seed_err  out  1  sticky flag: last load carried an all-zero seed.
- state_out  out  WIDTH  current LFSR state (debug/verification).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (clear).
- clear:
  - LFSR = SEED_DEFAULT, FSM = IDLE, bit count = 0, pack register = 0, stop_pending = 0.
  - ks_valid = 0, ks_byte = 0, seed_err = 0.
  - clear overrides every other input in the same cycle, including mid-byte and while in HOLD; the pending byte is discarded.
- Shift step, RUN only:
  - out_bit = state[WIDTH-1].
  - state <= {state[WIDTH-2:0], fb}.
  - pack <= {pack[6:0], out_bit}.
  - count <= count+1.
- FSM states IDLE, RUN, HOLD:
  - IDLE:
    - LFSR frozen.
    - load has priority over start when both are high.
    - load: state <= (seed_in==0) ? SEED_DEFAULT : seed_in; seed_err <= (seed_in==0). FSM stays in IDLE.
    - start (with load low): go to RUN, count <= 0.
    - stop in IDLE is ignored.
  - RUN:
    - One shift per cycle.
    - On the 8th shift: ks_byte <= completed byte, ks_valid <= 1, go to HOLD.
    - Latency: start sampled at edge E0; shifts occur at E1..E8; ks_valid is high after E8.
    - stop in RUN: go to IDLE at that edge with no shift; partial bits are discarded; the LFSR keeps its advanced state.
    - load and start are ignored in RUN.
  - HOLD:
    - LFSR frozen; ks_valid and ks_byte stable until the handshake.
    - stop sets stop_pending; the byte is still delivered.
    - On ks_valid && ks_ready: ks_valid <= 0, count <= 0; go to IDLE if stop_pending (or stop this cycle), otherwise RUN. stop_pending is cleared.
    - ks_byte retains its last value after the handshake.
    - Throughput: one byte per 9 cycles when ks_ready is held high.
- Outputs:
  - busy = (FSM != IDLE).
  - seed_err changes only on an accepted load or on clear.
- The LFSR never reaches the all-zero state: zero seeds are substituted, and a nonzero state cannot reach zero.
- After the 8th shift, count wraps to 0.

Test Plan:
- clear, then start, ks_ready=1 -> ks_valid high 8 cycles after start, ks_byte=0xAC; 9 cycles later ks_byte=0xE1.
- clear, then load with seed_in=0 -> state_out=0xACE1, seed_err=1; then load with seed_in=0x1234 -> state_out=0x1234, seed_err=0.
- clear, start, stop high on the cycle after exactly 3 shifts (state 0x59C3 -> 0xB387 -> 0x670F) -> IDLE, busy=0, state_out=0x670F, ks_valid never asserted.
- First byte presented with ks_ready=0 for 5 cycles -> ks_valid=1, ks_byte=0xAC, state_out stable throughout; ks_ready=1 -> handshake, next byte 0xE1 valid 8 cycles later.
- stop asserted during HOLD with ks_ready=0 -> byte 0xAC still held; on handshake FSM goes to IDLE, ks_valid=0, no further bytes.
- clear asserted mid-RUN (after 5 shifts) and mid-HOLD -> next cycle state_out=0xACE1, ks_valid=0, busy=0, ks_byte=0x00.
